lstm_fwd_ctrl: RTL and testbench
================================

// Module: lstm_fwd_ctrl
// PURPOSE
// - Sequences forward inference of the two-layer LSTM datapath over TIMESTEP steps.
// - Per step: evaluates layer-1 cells 0..L1C-1, then layer-2 cells 0..L2C-1, one cell at a time.
// - Drives every datapath read/write address and write strobe.
// - Start/busy/done handshake towards the top-level sequencer.
// PARAMETERS
// - TIMESTEP  7  sequence length (steps t = 0..TIMESTEP-1)
// - L1C       2  layer-1 cell count (== datapath LAYR1_CELL)
// - L2C       1  layer-2 cell count (== datapath LAYR2_CELL)
// - CELL_LAT  1  cycles from address valid to h/c valid at the cell output (>=1)
// - ADDR_W    9  address width of all outputs
// PORTS
// - clk         in   1       clock, all logic on posedge
// - rst         in   1       synchronous active-high reset
// - start       in   1       run request; sampled only in IDLE
// - busy        out  1       high in L1_RD/L1_WB/L2_RD/L2_WB
// - done        out  1       1-cycle pulse when the run completes
// - addr_x1     out  ADDR_W  layer-1 input row = t
// - rd_addr_h1  out  ADDR_W  row t; wr_addr_h1 out ADDR_W = (t+1)*L1C+j
// - rd_addr_c1  out  ADDR_W  t*L1C+j; wr_addr_c1 out ADDR_W = (t+1)*L1C+j
// - wr_addr_x2  out  ADDR_W  t*L1C+j; rd_addr_x2 out ADDR_W = row t
// - rd_addr_h2  out  ADDR_W  row t; wr_addr_h2 out ADDR_W = (t+1)*L2C+k
// - rd_addr_c2  out  ADDR_W  t*L2C+k; wr_addr_c2 out ADDR_W = (t+1)*L2C+k
// - wr_h1, wr_c1, wr_x2  out  1  write strobes, layer 1
// - wr_h2, wr_c2         out  1  write strobes, layer 2
// - cell_idx    out  ADDR_W  current cell j (layer 1) or k (layer 2)
// BEHAVIOUR
// - FSM states: IDLE, L1_RD, L1_WB, L2_RD, L2_WB, DONE.
// - IDLE: start=1 -> L1_RD with t=j=k=0; start in any other state is ignored.
// - L1_RD: wait CELL_LAT cycles (lat counter) -> L1_WB.
// - L1_WB: one cycle, wr_h1=wr_c1=wr_x2=1; then j<L1C-1 ? j++,L1_RD : j=0,L2_RD.
// - L2_RD: wait CELL_LAT cycles -> L2_WB.
// - L2_WB: one cycle, wr_h2=wr_c2=1; then k<L2C-1 ? k++,L2_RD : k=0 and
//   (t<TIMESTEP-1 ? t++,L1_RD : DONE).
// - DONE: done=1, busy=0, one cycle -> IDLE.
// - Memory row 0 of h/c holds the initial state; step t reads row t, writes row t+1.
// - All addresses are registered functions of state/t/j/k, stable for the whole cell
//   slot (RD+WB); 0 in IDLE/DONE.
// - Strobes are high only in the WB state of their own layer, never in RD, IDLE or DONE.
// - Per-cell cost CELL_LAT+1 cycles; busy time = TIMESTEP*(L1C+L2C)*(CELL_LAT+1).
// - Defaults: 42 busy cycles; done 43 cycles after the start-sampling edge.
// - Reset (any state, including mid-run): next state IDLE, t=j=k=lat=0, all outputs 0.
//   No strobe is issued in the reset cycle; an in-flight cell is abandoned.
// - Address arithmetic is unsigned ADDR_W and never wraps:
//   TIMESTEP*(max(L1C,L2C))+max(L1C,L2C) must be < 2**ADDR_W.
// CONFIGURATION
// - LSTM_CTRL_HOLD_EN defined: adds input port hold (1 bit, after start).
//   - hold=1 freezes state, t/j/k/lat and all address outputs.
//   - A WB cycle under hold suppresses its strobes and the write is issued on the
//     first cycle with hold=0.
//   - busy is unaffected; hold in IDLE also blocks start.
// - LSTM_CTRL_HOLD_EN undefined: no hold port; FSM never stalls.
// TESTING
// - Reset then start pulse (defaults) -> busy high 42 cycles.
//   - done single pulse at cycle 43; wr_h1 pulses 14, wr_h2 pulses 7.
// - First L1_WB -> wr_addr_h1=2, wr_addr_c1=2, wr_addr_x2=0, rd_addr_h1=0, rd_addr_c1=0.
//   - Second L1_WB -> wr_addr_h1=3, wr_addr_x2=1.
// - Final L2_WB (t=6,k=0) -> wr_addr_h2=7, rd_addr_x2=6, rd_addr_c2=6.
// - rst asserted during 20th busy cycle -> next cycle IDLE, all outputs 0, no strobe;
//   a new start runs the full 42 cycles from t=0.
// - start held high for the whole run -> ignored while busy.
//   - One cycle after DONE (start sampled in IDLE) -> new run begins.
// - LSTM_CTRL_HOLD_EN, hold=1 for 5 cycles across first L1_WB
//   -> strobes deferred 5 cycles; done at cycle 48.

Source files
------------

// File: rtl/lstm_fwd_ctrl.sv
// Cell-by-cell sequencer for the two-layer LSTM forward pass: drives addresses and write strobes, start/busy/done handshake.
// Optional stall input `hold` is present when LSTM_CTRL_HOLD_EN is defined; without it the FSM never stalls.
module lstm_fwd_ctrl #(
  parameter int TIMESTEP = 7,
  parameter int L1C      = 2,
  parameter int L2C      = 1,
  parameter int CELL_LAT = 1,
  parameter int ADDR_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef LSTM_CTRL_HOLD_EN
  input  logic              hold,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr_x1,
  output logic [ADDR_W-1:0] rd_addr_h1,
  output logic [ADDR_W-1:0] wr_addr_h1,
  output logic [ADDR_W-1:0] rd_addr_c1,
  output logic [ADDR_W-1:0] wr_addr_c1,
  output logic [ADDR_W-1:0] wr_addr_x2,
  output logic [ADDR_W-1:0] rd_addr_x2,
  output logic [ADDR_W-1:0] rd_addr_h2,
  output logic [ADDR_W-1:0] wr_addr_h2,
  output logic [ADDR_W-1:0] rd_addr_c2,
  output logic [ADDR_W-1:0] wr_addr_c2,
  output logic              wr_h1,
  output logic              wr_c1,
  output logic              wr_x2,
  output logic              wr_h2,
  output logic              wr_c2,
  output logic [ADDR_W-1:0] cell_idx
);

  typedef enum logic [2:0] {IDLE, L1_RD, L1_WB, L2_RD, L2_WB, DONE} state_t;

  localparam int LAT_W = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(CELL_LAT - 1);
  localparam logic [ADDR_W-1:0] L1C_A    = ADDR_W'(L1C);
  localparam logic [ADDR_W-1:0] L2C_A    = ADDR_W'(L2C);
  localparam logic [ADDR_W-1:0] L1C_LAST = ADDR_W'(L1C - 1);
  localparam logic [ADDR_W-1:0] L2C_LAST = ADDR_W'(L2C - 1);
  localparam logic [ADDR_W-1:0] T_LAST   = ADDR_W'(TIMESTEP - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] t, j, k, t_nxt, j_nxt, k_nxt;
  logic [LAT_W-1:0]  lat, lat_nxt;
  logic              stall;
  logic              wr_ok;
  logic [ADDR_W-1:0] row1_cur, row1_nxt, row2_cur, row2_nxt;

`ifdef LSTM_CTRL_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  // A write is never issued in the reset cycle or while stalled; a stalled WB retries next cycle.
  assign wr_ok = ~rst & ~stall;

  assign row1_cur = t * L1C_A + j;
  assign row1_nxt = row1_cur + L1C_A;
  assign row2_cur = t * L2C_A + k;
  assign row2_nxt = row2_cur + L2C_A;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
      j     <= '0;
      k     <= '0;
      lat   <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      j     <= j_nxt;
      k     <= k_nxt;
      lat   <= lat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    j_nxt     = j;
    k_nxt     = k;
    lat_nxt   = lat;
    if (!stall) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = L1_RD;
            t_nxt     = '0;
            j_nxt     = '0;
            k_nxt     = '0;
            lat_nxt   = '0;
          end
        end
        L1_RD: begin
          if (lat == LAT_LAST) begin
            lat_nxt   = '0;
            state_nxt = L1_WB;
          end else begin
            lat_nxt = lat + 1'b1;
          end
        end
        L1_WB: begin
          if (j < L1C_LAST) begin
            j_nxt     = j + 1'b1;
            state_nxt = L1_RD;
          end else begin
            j_nxt     = '0;
            state_nxt = L2_RD;
          end
        end
        L2_RD: begin
          if (lat == LAT_LAST) begin
            lat_nxt   = '0;
            state_nxt = L2_WB;
          end else begin
            lat_nxt = lat + 1'b1;
          end
        end
        L2_WB: begin
          if (k < L2C_LAST) begin
            k_nxt     = k + 1'b1;
            state_nxt = L2_RD;
          end else begin
            k_nxt = '0;
            if (t < T_LAST) begin
              t_nxt     = t + 1'b1;
              state_nxt = L1_RD;
            end else begin
              state_nxt = DONE;
            end
          end
        end
        DONE: begin
          t_nxt     = '0;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    addr_x1    = '0;
    rd_addr_h1 = '0;
    wr_addr_h1 = '0;
    rd_addr_c1 = '0;
    wr_addr_c1 = '0;
    wr_addr_x2 = '0;
    rd_addr_x2 = '0;
    rd_addr_h2 = '0;
    wr_addr_h2 = '0;
    rd_addr_c2 = '0;
    wr_addr_c2 = '0;
    wr_h1      = 1'b0;
    wr_c1      = 1'b0;
    wr_x2      = 1'b0;
    wr_h2      = 1'b0;
    wr_c2      = 1'b0;
    cell_idx   = '0;
    case (state)
      L1_RD, L1_WB: begin
        busy       = 1'b1;
        cell_idx   = j;
        addr_x1    = t;
        rd_addr_h1 = t;
        rd_addr_c1 = row1_cur;
        wr_addr_h1 = row1_nxt;
        wr_addr_c1 = row1_nxt;
        wr_addr_x2 = row1_cur;
        if (state == L1_WB && wr_ok) begin
          wr_h1 = 1'b1;
          wr_c1 = 1'b1;
          wr_x2 = 1'b1;
        end
      end
      L2_RD, L2_WB: begin
        busy       = 1'b1;
        cell_idx   = k;
        rd_addr_x2 = t;
        rd_addr_h2 = t;
        rd_addr_c2 = row2_cur;
        wr_addr_h2 = row2_nxt;
        wr_addr_c2 = row2_nxt;
        if (state == L2_WB && wr_ok) begin
          wr_h2 = 1'b1;
          wr_c2 = 1'b1;
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lstm_fwd_ctrl.sv
// Bench for lstm_fwd_ctrl: a write-event scoreboard plus per-scenario timing checks.
module tb_lstm_fwd_ctrl;
  localparam int AW = 9;
  localparam int TS = 7;
  localparam int L1 = 2;
  localparam int L2 = 1;

  logic          clk = 1'b0;
  logic          rst, start;
`ifdef LSTM_CTRL_HOLD_EN
  logic          hold;
`endif
  logic          busy, done;
  logic [AW-1:0] addr_x1, rd_addr_h1, wr_addr_h1, rd_addr_c1, wr_addr_c1, wr_addr_x2;
  logic [AW-1:0] rd_addr_x2, rd_addr_h2, wr_addr_h2, rd_addr_c2, wr_addr_c2, cell_idx;
  logic          wr_h1, wr_c1, wr_x2, wr_h2, wr_c2;

  int checks = 0;
  int errors = 0;
  int nh1 = 0;
  int nh2 = 0;

  typedef struct packed {
    logic [4:0]    strb;
    logic [AW-1:0] wa_h, wa_c, wa_x2, ra_h, ra_c, ra_x, cidx;
  } wb_t;
  wb_t q[$];

  lstm_fwd_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef LSTM_CTRL_HOLD_EN
    .hold(hold),
`endif
    .busy(busy), .done(done),
    .addr_x1(addr_x1), .rd_addr_h1(rd_addr_h1), .wr_addr_h1(wr_addr_h1),
    .rd_addr_c1(rd_addr_c1), .wr_addr_c1(wr_addr_c1), .wr_addr_x2(wr_addr_x2),
    .rd_addr_x2(rd_addr_x2), .rd_addr_h2(rd_addr_h2), .wr_addr_h2(wr_addr_h2),
    .rd_addr_c2(rd_addr_c2), .wr_addr_c2(wr_addr_c2),
    .wr_h1(wr_h1), .wr_c1(wr_c1), .wr_x2(wr_x2), .wr_h2(wr_h2), .wr_c2(wr_c2),
    .cell_idx(cell_idx)
  );

  always #5 clk = ~clk;

  // Expected write-back events for one complete run, in issue order.
  function automatic void push_run();
    wb_t e;
    for (int t = 0; t < TS; t++) begin
      for (int j = 0; j < L1; j++) begin
        e.strb = 5'b11100;
        e.wa_h = AW'((t + 1) * L1 + j);
        e.wa_c = AW'((t + 1) * L1 + j);
        e.wa_x2 = AW'(t * L1 + j);
        e.ra_h = AW'(t);
        e.ra_c = AW'(t * L1 + j);
        e.ra_x = AW'(t);
        e.cidx = AW'(j);
        q.push_back(e);
      end
      for (int k = 0; k < L2; k++) begin
        e.strb = 5'b00011;
        e.wa_h = AW'((t + 1) * L2 + k);
        e.wa_c = AW'((t + 1) * L2 + k);
        e.wa_x2 = '0;
        e.ra_h = AW'(t);
        e.ra_c = AW'(t * L2 + k);
        e.ra_x = AW'(t);
        e.cidx = AW'(k);
        q.push_back(e);
      end
    end
  endfunction

  always @(negedge clk) begin
    wb_t a, e;
    if (wr_h1) nh1++;
    if (wr_h2) nh2++;
    if (wr_h1 | wr_c1 | wr_x2 | wr_h2 | wr_c2) begin
      a.strb = {wr_h1, wr_c1, wr_x2, wr_h2, wr_c2};
      a.cidx = cell_idx;
      if (wr_h1 | wr_c1 | wr_x2) begin
        a.wa_h = wr_addr_h1; a.wa_c = wr_addr_c1; a.wa_x2 = wr_addr_x2;
        a.ra_h = rd_addr_h1; a.ra_c = rd_addr_c1; a.ra_x = addr_x1;
      end else begin
        a.wa_h = wr_addr_h2; a.wa_c = wr_addr_c2; a.wa_x2 = '0;
        a.ra_h = rd_addr_h2; a.ra_c = rd_addr_c2; a.ra_x = rd_addr_x2;
      end
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got %h want none", a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL write_event got %h want %h", a, e);
        end
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL strobe_while_idle busy got %b want 1", busy);
      end
    end
  end

  task automatic wait_run(output int nbusy, output int ndone);
    nbusy = 0;
    ndone = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ndone = n;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL %s_busy_done got %b want 00", tag, {busy, done});
    end
    checks++;
    if ({wr_h1, wr_c1, wr_x2, wr_h2, wr_c2} !== 5'b0) begin
      errors++;
      $display("FAIL %s_strobes got %b want 00000", tag, {wr_h1, wr_c1, wr_x2, wr_h2, wr_c2});
    end
    checks++;
    if ({addr_x1, rd_addr_h1, wr_addr_h1, rd_addr_c1, wr_addr_c1, wr_addr_x2, rd_addr_x2,
         rd_addr_h2, wr_addr_h2, rd_addr_c2, wr_addr_c2, cell_idx} !== '0) begin
      errors++;
      $display("FAIL %s_addresses got nonzero want all 0 (x1=%0d wh1=%0d idx=%0d)",
               tag, addr_x1, wr_addr_h1, cell_idx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic test_full_run();
    int nb, nd;
    q.delete();
    push_run();
    nh1 = 0;
    nh2 = 0;
    pulse_start();
    wait_run(nb, nd);
    checks++;
    if (nb != 42) begin errors++; $display("FAIL busy_cycles got %0d want 42", nb); end
    checks++;
    if (nd != 43) begin errors++; $display("FAIL done_cycle got %0d want 43", nd); end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL after_done got busy,done=%b want 00", {busy, done});
    end
    checks++;
    if (nh1 != 14 || nh2 != 7) begin
      errors++;
      $display("FAIL strobe_counts got h1=%0d h2=%0d want 14 7", nh1, nh2);
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL missing_writes got %0d left want 0", q.size()); end
  endtask

  task automatic test_reset_mid_run();
    int nb;
    q.delete();
    push_run();
    pulse_start();
    nb = 0;
    for (int n = 0; n < 100 && nb < 19; n++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    // Cycle 20 is the L1 write-back of step 3; reset during it must mask the strobes.
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({wr_h1, wr_c1, wr_x2, wr_h2, wr_c2} !== 5'b0) begin
      errors++;
      $display("FAIL reset_cycle_strobes got %b want 00000", {wr_h1, wr_c1, wr_x2, wr_h2, wr_c2});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrun_reset");
    q.delete();
    test_full_run();
  endtask

  task automatic test_start_held();
    int nb, nd;
    q.delete();
    push_run();
    push_run();
    nh1 = 0;
    @(negedge clk);
    start = 1'b1;
    wait_run(nb, nd);
    checks++;
    if (nb != 42 || nd != 43) begin
      errors++;
      $display("FAIL held_first_run got busy=%0d done=%0d want 42 43", nb, nd);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL held_idle_gap busy got %b want 0", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL held_restart busy got %b want 1", busy); end
    start = 1'b0;
    wait_run(nb, nd);
    checks++;
    if (nb + 1 != 42 || nd + 1 != 43) begin
      errors++;
      $display("FAIL held_second_run got busy=%0d done=%0d want 42 43", nb + 1, nd + 1);
    end
    checks++;
    if (nh1 != 28 || q.size() != 0) begin
      errors++;
      $display("FAIL held_writes got h1=%0d left=%0d want 28 0", nh1, q.size());
    end
  endtask

`ifdef LSTM_CTRL_HOLD_EN
  task automatic test_hold();
    int nb, nd, sh;
    q.delete();
    push_run();
    nh1 = 0;
    sh = 0;
    pulse_start();
    @(posedge clk);
    #1 hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sh += int'(wr_h1);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy got %b want 1", busy); end
    end
    checks++;
    if (sh != 0) begin errors++; $display("FAIL hold_strobe got %0d want 0", sh); end
    @(posedge clk);
    #1 hold = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_h1 !== 1'b1) begin errors++; $display("FAIL hold_release_strobe got %b want 1", wr_h1); end
    wait_run(nb, nd);
    checks++;
    if (nd + 7 != 48) begin errors++; $display("FAIL hold_done_cycle got %0d want 48", nd + 7); end
    checks++;
    if (nh1 != 14 || q.size() != 0) begin
      errors++;
      $display("FAIL hold_writes got h1=%0d left=%0d want 14 0", nh1, q.size());
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
`ifdef LSTM_CTRL_HOLD_EN
    hold = 1'b0;
`endif
    test_reset();
    test_full_run();
    test_reset_mid_run();
    test_start_held();
`ifdef LSTM_CTRL_HOLD_EN
    test_hold();
`endif
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
